// File: rtl/mips_mc_controller_ws.sv
// Multi-cycle MIPS control FSM with memory wait-state handling, timeout fault detection
// and a retired-instruction counter.
module mips_mc_controller_ws #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_srcA,
    output logic             pc_load,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_srcB,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_ctrl,
    output logic [3:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBeq     = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11,
        StError   = 4'd12
    } state_e;

    localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJump  = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       fn_ok;
    logic [2:0] fn_ctrl;
    logic       timeout;
    logic       retire;

    always_comb begin
        fn_ok   = 1'b1;
        fn_ctrl = 3'b010;
        unique case (funct)
            6'b100000: fn_ctrl = 3'b010;
            6'b100010: fn_ctrl = 3'b110;
            6'b100100: fn_ctrl = 3'b000;
            6'b100101: fn_ctrl = 3'b001;
            6'b101010: fn_ctrl = 3'b111;
            default:   fn_ok   = 1'b0;
        endcase
    end

    // wait_q holds the not-ready cycles already seen, so this cycle is the (wait_q+1)-th
    assign timeout = (TIMEOUT != 0) && !mem_ready && ((32'(wait_q) + 32'd1) == TIMEOUT);

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        IorD       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_srcA   = 1'b0;
        pc_load    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_srcB   = 2'b00;
        pc_src     = 2'b00;
        alu_ctrl   = 3'b010;
        unique case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                alu_srcB = 2'b01;
                ir_write = mem_ready;
                pc_load  = mem_ready;
                if (mem_ready)    state_d = StDecode;
                else if (timeout) state_d = StError;
                else              wait_d  = wait_q + WaitW'(1);
            end
            StDecode: begin
                alu_srcB = 2'b11;
                unique case (opcode)
                    OpRType:    state_d = StRExec;
                    OpLw, OpSw: state_d = StMemAddr;
                    OpBeq:      state_d = StBeq;
                    OpJump:     state_d = StJump;
                    OpAddi:     state_d = StIExec;
                    default:    state_d = StError;
                endcase
            end
            StMemAddr: begin
                alu_srcA = 1'b1;
                alu_srcB = 2'b10;
                if (opcode == OpLw)      state_d = StMemRd;
                else if (opcode == OpSw) state_d = StMemWr;
                else                     state_d = StError;
            end
            StMemRd: begin
                IorD     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)    state_d = StMemWb;
                else if (timeout) state_d = StError;
                else              wait_d  = wait_q + WaitW'(1);
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready)    state_d = StFetch;
                else if (timeout) state_d = StError;
                else              wait_d  = wait_q + WaitW'(1);
            end
            StRExec: begin
                alu_srcA = 1'b1;
                alu_ctrl = fn_ctrl;
                state_d  = fn_ok ? StRWb : StError;
            end
            StRWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_ctrl  = fn_ctrl;
                state_d   = StFetch;
            end
            StBeq: begin
                alu_srcA = 1'b1;
                alu_ctrl = 3'b110;
                pc_src   = 2'b01;
                pc_load  = zero;
                state_d  = StFetch;
            end
            StJump: begin
                pc_src  = 2'b10;
                pc_load = 1'b1;
                state_d = StFetch;
            end
            StIExec: begin
                alu_srcA = 1'b1;
                alu_srcB = 2'b10;
                state_d  = StIWb;
            end
            StIWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StError: state_d = StError;
            default: state_d = StError;
        endcase
        // Side-effecting strobes stay quiet for the whole reset cycle
        if (!rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_load   = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign retire    = (state_d == StFetch) && (state_q != StFetch) && (state_q != StError);
    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign err     = (state_q == StError);
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_controller_ws.sv
// Scoreboard bench: directed per-cycle vectors push expected outputs; a negedge monitor
// pops and compares them against the controller.
module tb_mips_mc_controller_ws;

    logic       clk, rst, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       IorD, ir_write, reg_dst, mem_to_reg, reg_write, alu_srcA, pc_load;
    logic       mem_read, mem_write, err;
    logic [1:0] alu_srcB, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state, retired;

    mips_mc_controller_ws #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .IorD(IorD), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_srcA(alu_srcA),
        .pc_load(pc_load), .mem_read(mem_read), .mem_write(mem_write),
        .alu_srcB(alu_srcB), .pc_src(pc_src), .alu_ctrl(alu_ctrl), .state(state),
        .err(err), .retired(retired)
    );

    // Control word: {IorD,ir_write,reg_dst,mem_to_reg,reg_write,alu_srcA,pc_load,
    //                mem_read,mem_write,alu_srcB[1:0],pc_src[1:0],alu_ctrl[2:0]}
    localparam logic [15:0] FRdy  = 16'h4322, FWait = 16'h0122, FRst  = 16'h0022;
    localparam logic [15:0] Dec   = 16'h0062, MAddr = 16'h0442, MRd   = 16'h8102;
    localparam logic [15:0] MRdR  = 16'h8002, MWb   = 16'h1802, MWr   = 16'h8082;
    localparam logic [15:0] RxAdd = 16'h0402, RxSub = 16'h0406, RxSlt = 16'h0407;
    localparam logic [15:0] RwAdd = 16'h2802, RwSub = 16'h2806, RwSlt = 16'h2807;
    localparam logic [15:0] BeqT  = 16'h060E, BeqF  = 16'h040E, Jmp   = 16'h0212;
    localparam logic [15:0] IEx   = 16'h0442, IWb   = 16'h0802, ErrC  = 16'h0002;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic [3:0]  ret;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   vec = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [3:0] st,
                       input logic [15:0] c, input int rt);
        exp_t e;
        rst = r; opcode = op; funct = fn; zero = z; mem_ready = rdy;
        e.st = st; e.ctrl = c; e.ret = rt[3:0]; e.idx = vec;
        vec++;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        logic        e_err;
        if (q.size() > 0) begin
            e     = q.pop_front();
            act   = {IorD, ir_write, reg_dst, mem_to_reg, reg_write, alu_srcA, pc_load,
                     mem_read, mem_write, alu_srcB, pc_src, alu_ctrl};
            e_err = (e.st == 4'd12);
            compared += 4;
            if (state !== e.st) begin
                mismatched++;
                $display("FAIL state vec %0d: got %0d want %0d", e.idx, state, e.st);
            end
            if (act !== e.ctrl) begin
                mismatched++;
                $display("FAIL ctrl vec %0d: got %h want %h", e.idx, act, e.ctrl);
            end
            if (err !== e_err) begin
                mismatched++;
                $display("FAIL err vec %0d: got %b want %b", e.idx, err, e_err);
            end
            if (retired !== e.ret) begin
                mismatched++;
                $display("FAIL retired vec %0d: got %0d want %0d", e.idx, retired, e.ret);
            end
        end
    end

    initial begin
        rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 6'h00, 6'h20, 0, 1, 4'd0, FRst, 0);
        // add
        cyc(1, 6'h00, 6'h20, 0, 1, 4'd0, FRdy, 0);
        cyc(1, 6'h00, 6'h20, 0, 1, 4'd1, Dec, 0);
        cyc(1, 6'h00, 6'h20, 0, 1, 4'd6, RxAdd, 0);
        cyc(1, 6'h00, 6'h20, 0, 1, 4'd7, RwAdd, 0);
        // sub
        cyc(1, 6'h00, 6'h22, 0, 1, 4'd0, FRdy, 1);
        cyc(1, 6'h00, 6'h22, 0, 1, 4'd1, Dec, 1);
        cyc(1, 6'h00, 6'h22, 0, 1, 4'd6, RxSub, 1);
        cyc(1, 6'h00, 6'h22, 0, 1, 4'd7, RwSub, 1);
        // slt
        cyc(1, 6'h00, 6'h2A, 0, 1, 4'd0, FRdy, 2);
        cyc(1, 6'h00, 6'h2A, 0, 1, 4'd1, Dec, 2);
        cyc(1, 6'h00, 6'h2A, 0, 1, 4'd6, RxSlt, 2);
        cyc(1, 6'h00, 6'h2A, 0, 1, 4'd7, RwSlt, 2);
        // lw with three not-ready cycles in MEM_RD
        cyc(1, 6'h23, 6'h00, 0, 1, 4'd0, FRdy, 3);
        cyc(1, 6'h23, 6'h00, 0, 1, 4'd1, Dec, 3);
        cyc(1, 6'h23, 6'h00, 0, 1, 4'd2, MAddr, 3);
        cyc(1, 6'h23, 6'h00, 0, 0, 4'd3, MRd, 3);
        cyc(1, 6'h23, 6'h00, 0, 0, 4'd3, MRd, 3);
        cyc(1, 6'h23, 6'h00, 0, 0, 4'd3, MRd, 3);
        cyc(1, 6'h23, 6'h00, 0, 1, 4'd3, MRd, 3);
        cyc(1, 6'h23, 6'h00, 0, 1, 4'd4, MWb, 3);
        // sw with one not-ready cycle
        cyc(1, 6'h2B, 6'h00, 0, 1, 4'd0, FRdy, 4);
        cyc(1, 6'h2B, 6'h00, 0, 1, 4'd1, Dec, 4);
        cyc(1, 6'h2B, 6'h00, 0, 1, 4'd2, MAddr, 4);
        cyc(1, 6'h2B, 6'h00, 0, 0, 4'd5, MWr, 4);
        cyc(1, 6'h2B, 6'h00, 0, 1, 4'd5, MWr, 4);
        // beq taken, then not taken, with one fetch wait
        cyc(1, 6'h04, 6'h00, 0, 0, 4'd0, FWait, 5);
        cyc(1, 6'h04, 6'h00, 0, 1, 4'd0, FRdy, 5);
        cyc(1, 6'h04, 6'h00, 0, 1, 4'd1, Dec, 5);
        cyc(1, 6'h04, 6'h00, 1, 1, 4'd8, BeqT, 5);
        cyc(1, 6'h04, 6'h00, 0, 1, 4'd0, FRdy, 6);
        cyc(1, 6'h04, 6'h00, 0, 1, 4'd1, Dec, 6);
        cyc(1, 6'h04, 6'h00, 0, 1, 4'd8, BeqF, 6);
        // addi
        cyc(1, 6'h08, 6'h00, 0, 1, 4'd0, FRdy, 7);
        cyc(1, 6'h08, 6'h00, 0, 1, 4'd1, Dec, 7);
        cyc(1, 6'h08, 6'h00, 0, 1, 4'd10, IEx, 7);
        cyc(1, 6'h08, 6'h00, 0, 1, 4'd11, IWb, 7);
        // eight jumps take retired 8 -> 15 -> 0
        for (int j = 0; j < 8; j++) begin
            cyc(1, 6'h02, 6'h00, 0, 1, 4'd0, FRdy, (8 + j) % 16);
            cyc(1, 6'h02, 6'h00, 0, 1, 4'd1, Dec, (8 + j) % 16);
            cyc(1, 6'h02, 6'h00, 0, 1, 4'd9, Jmp, (8 + j) % 16);
        end
        // fetch timeout: 15 not-ready cycles, then sticky ERROR
        for (int k = 0; k < 15; k++) cyc(1, 6'h02, 6'h00, 0, 0, 4'd0, FWait, 0);
        cyc(1, 6'h02, 6'h00, 0, 1, 4'd12, ErrC, 0);
        cyc(1, 6'h02, 6'h00, 0, 1, 4'd12, ErrC, 0);
        cyc(0, 6'h02, 6'h00, 0, 1, 4'd12, ErrC, 0);
        // jump, then ready on the 15th cycle, then illegal opcode
        cyc(1, 6'h02, 6'h00, 0, 1, 4'd0, FRdy, 0);
        cyc(1, 6'h02, 6'h00, 0, 1, 4'd1, Dec, 0);
        cyc(1, 6'h02, 6'h00, 0, 1, 4'd9, Jmp, 0);
        for (int k = 0; k < 14; k++) cyc(1, 6'h3F, 6'h00, 0, 0, 4'd0, FWait, 1);
        cyc(1, 6'h3F, 6'h00, 0, 1, 4'd0, FRdy, 1);
        cyc(1, 6'h3F, 6'h00, 0, 1, 4'd1, Dec, 1);
        cyc(1, 6'h3F, 6'h00, 0, 1, 4'd12, ErrC, 1);
        cyc(1, 6'h3F, 6'h00, 0, 1, 4'd12, ErrC, 1);
        cyc(0, 6'h3F, 6'h00, 0, 1, 4'd12, ErrC, 1);
        // R-type with undefined funct
        cyc(1, 6'h00, 6'h00, 0, 1, 4'd0, FRdy, 0);
        cyc(1, 6'h00, 6'h00, 0, 1, 4'd1, Dec, 0);
        cyc(1, 6'h00, 6'h00, 0, 1, 4'd6, RxAdd, 0);
        cyc(1, 6'h00, 6'h00, 0, 1, 4'd12, ErrC, 0);
        cyc(0, 6'h00, 6'h00, 0, 1, 4'd12, ErrC, 0);
        // reset in the middle of a MEM_RD wait
        cyc(1, 6'h23, 6'h00, 0, 1, 4'd0, FRdy, 0);
        cyc(1, 6'h23, 6'h00, 0, 1, 4'd1, Dec, 0);
        cyc(1, 6'h23, 6'h00, 0, 1, 4'd2, MAddr, 0);
        cyc(1, 6'h23, 6'h00, 0, 0, 4'd3, MRd, 0);
        cyc(0, 6'h23, 6'h00, 0, 0, 4'd3, MRdR, 0);
        cyc(1, 6'h02, 6'h00, 0, 1, 4'd0, FRdy, 0);
        cyc(1, 6'h02, 6'h00, 0, 1, 4'd1, Dec, 0);
        cyc(1, 6'h02, 6'h00, 0, 1, 4'd9, Jmp, 0);
        cyc(1, 6'h02, 6'h00, 0, 0, 4'd0, FWait, 1);

        for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
